adc_spi_reader: RTL and testbench

Serial ADC front-end for the DE-10 Lite shield. On each start request it runs one SPI frame to the shield's ADC for the requested channel (1..NUM_CH, the same numbering the channel-cycling counter produces), shifts in the conversion result and stores it in a per-channel result register. It sits between the channel counter and the game's input-decode logic, which reads `ch_data_o`.

---
 rtl/adc_spi_reader_pkg.sv | 25 ++
 rtl/adc_spi_reader_if.sv | 31 +++
 rtl/adc_spi_reader_sclk_gen.sv | 42 ++++
 rtl/adc_spi_reader.sv | 151 +++++++++++++++
 tb/tb_adc_spi_reader.sv | 319 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/adc_spi_reader_pkg.sv
// Shared constants, FSM state type and frame-length helper for the ADC SPI reader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package adc_pkg;

  // Command field: start, single-ended, 3-bit channel select.
  localparam int CMD_BITS = 5;

  // First two command bits sent on every frame.
  localparam logic CMD_START = 1'b1;
  localparam logic CMD_SGL   = 1'b1;

  // Full frame in SCLK periods: command, null bit, then the result.
  function automatic int frame_bits(input int data_w);
    return CMD_BITS + 1 + data_w;
  endfunction

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } adc_state_e;

endpackage

// File: rtl/adc_spi_reader_if.sv
// Request/result bus between the channel sequencer, the input decoder and the ADC reader.
// Latency: n/a (wiring only); NUM_CH/DATA_W must match the reader instance.
// Backpressure: none on the bus; the reader ignores start_i while busy_o is high.
interface adc_spi_reader_if #(
  parameter int NUM_CH = 5,
  parameter int DATA_W = 10
);
  logic [4:0]               channel_i;
  logic                     start_i;
  logic                     miso_i;
  logic                     sclk_o;
  logic                     cs_n_o;
  logic                     mosi_o;
  logic                     busy_o;
  logic                     sample_valid_o;
  logic [4:0]               sample_ch_o;
  logic [DATA_W-1:0]        sample_o;
  logic [NUM_CH*DATA_W-1:0] ch_data_o;

  // Reader side.
  modport slave (
    input  channel_i, start_i, miso_i,
    output sclk_o, cs_n_o, mosi_o, busy_o, sample_valid_o, sample_ch_o, sample_o, ch_data_o
  );

  // Requester / ADC side.
  modport master (
    output channel_i, start_i, miso_i,
    input  sclk_o, cs_n_o, mosi_o, busy_o, sample_valid_o, sample_ch_o, sample_o, ch_data_o
  );
endinterface

// File: rtl/adc_spi_reader_sclk_gen.sv
// SCLK generator: CLK_DIV-cycle half periods, low half first, with edge strobes.
// Latency: first rise_o strobe CLK_DIV-1 cycles after en_i rises; sclk_o goes high the cycle after.
// Backpressure: none; dropping en_i returns SCLK to idle-low with a cleared counter.
module adc_sclk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic en_i,
  output logic sclk_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] half_cnt;
  logic             half_end;

  // Strobes are high in the cycle whose closing edge toggles SCLK.
  assign half_end = en_i && (half_cnt == CNT_LAST);
  assign rise_o   = half_end && !sclk_o;
  assign fall_o   = half_end && sclk_o;

  // Half-period counter wraps at CLK_DIV-1 and toggles SCLK on each wrap.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      half_cnt <= '0;
      sclk_o   <= 1'b0;
    end else if (!en_i) begin
      half_cnt <= '0;
      sclk_o   <= 1'b0;
    end else if (half_end) begin
      half_cnt <= '0;
      sclk_o   <= ~sclk_o;
    end else begin
      half_cnt <= half_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/adc_spi_reader.sv
// Runs one SPI frame per start request and stores the result in a per-channel bank (option: ADC_AVG_EN).
// Latency: strobe CLK_DIV*(1+2*FRAME_BITS)+1 cycles after start is sampled; busy for (2+2*FRAME_BITS)*CLK_DIV cycles.
// Backpressure: start_i is level-sampled only while idle; requests during a frame are dropped.
module adc_spi_reader
  import adc_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int NUM_CH  = 5,
  parameter int DATA_W  = 10
) (
  input logic              clk_i,
  input logic              reset_i,
  adc_spi_reader_if.slave  bus
);

  localparam int FRAME_BITS = frame_bits(DATA_W);
  localparam int BIT_W      = $clog2(FRAME_BITS);
  localparam int DLY_W      = $clog2(CLK_DIV);

  localparam logic [BIT_W-1:0] LAST_BIT   = BIT_W'(FRAME_BITS - 1);
  localparam logic [BIT_W-1:0] DATA_FIRST = BIT_W'(CMD_BITS + 1);
  localparam logic [DLY_W-1:0] DLY_LAST   = DLY_W'(CLK_DIV - 1);

  adc_state_e               state;
  logic [DLY_W-1:0]         dly_cnt;
  logic [BIT_W-1:0]         bit_cnt;
  logic [4:0]               ch_lat;
  logic [CMD_BITS-1:0]      cmd_sr;
  logic [DATA_W-1:0]        shreg;
  logic [NUM_CH*DATA_W-1:0] bank;
  logic [DATA_W-1:0]        bank_wr;
  logic                     sclk_rise;
  logic                     sclk_fall;
  logic                     ch_ok;
  logic [4:0]               req_m1;
  logic [4:0]               lat_m1;
  logic [2:0]               ch_idx;

  assign ch_ok  = (bus.channel_i != 5'd0) && (bus.channel_i <= 5'(NUM_CH));
  assign req_m1 = bus.channel_i - 5'd1;
  assign lat_m1 = ch_lat - 5'd1;
  assign ch_idx = lat_m1[2:0];

  assign bus.ch_data_o = bank;

  adc_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .en_i    (state == SHIFT),
    .sclk_o  (bus.sclk_o),
    .rise_o  (sclk_rise),
    .fall_o  (sclk_fall)
  );

`ifdef ADC_AVG_EN
  logic [NUM_CH-1:0] written;
  logic [DATA_W:0]   avg_sum;

  // Rounded mean of the stored and new value; raw value on a slot's first write.
  always_comb begin
    avg_sum = {1'b0, bank[ch_idx*DATA_W +: DATA_W]} + {1'b0, shreg} + (DATA_W+1)'(1);
    bank_wr = written[ch_idx] ? avg_sum[DATA_W:1] : shreg;
  end
`else
  assign bank_wr = shreg;
`endif

  // Frame sequencer: chip select, command shift-out, result shift-in and bank write.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state              <= IDLE;
      dly_cnt            <= '0;
      bit_cnt            <= '0;
      ch_lat             <= '0;
      cmd_sr             <= '0;
      shreg              <= '0;
      bank               <= '0;
      bus.cs_n_o         <= 1'b1;
      bus.mosi_o         <= 1'b0;
      bus.busy_o         <= 1'b0;
      bus.sample_valid_o <= 1'b0;
      bus.sample_ch_o    <= '0;
      bus.sample_o       <= '0;
`ifdef ADC_AVG_EN
      written            <= '0;
`endif
    end else begin
      bus.sample_valid_o <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start_i && ch_ok) begin
            state      <= SETUP;
            ch_lat     <= bus.channel_i;
            // Bits still to send after the start bit; the trailing zero keeps MOSI low afterwards.
            cmd_sr     <= {CMD_SGL, req_m1[2:0], 1'b0};
            bus.mosi_o <= CMD_START;
            bus.cs_n_o <= 1'b0;
            bus.busy_o <= 1'b1;
            dly_cnt    <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
          end
        end
        SETUP: begin
          if (dly_cnt == DLY_LAST) begin
            dly_cnt <= '0;
            state   <= SHIFT;
          end else begin
            dly_cnt <= dly_cnt + 1'b1;
          end
        end
        SHIFT: begin
          // The ADC's null bit and the command-phase bits are never shifted in.
          if (sclk_rise && (bit_cnt >= DATA_FIRST)) begin
            shreg <= (shreg << 1) | DATA_W'(bus.miso_i);
          end
          if (sclk_fall) begin
            bus.mosi_o <= cmd_sr[CMD_BITS-1];
            cmd_sr     <= cmd_sr << 1;
            if (bit_cnt == LAST_BIT) begin
              bit_cnt            <= '0;
              state              <= DONE;
              bus.cs_n_o         <= 1'b1;
              bus.mosi_o         <= 1'b0;
              bus.sample_valid_o <= 1'b1;
              bus.sample_o       <= shreg;
              bus.sample_ch_o    <= ch_lat;
              bank[ch_idx*DATA_W +: DATA_W] <= bank_wr;
`ifdef ADC_AVG_EN
              written[ch_idx]    <= 1'b1;
`endif
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        DONE: begin
          if (dly_cnt == DLY_LAST) begin
            dly_cnt    <= '0;
            state      <= IDLE;
            bus.busy_o <= 1'b0;
          end else begin
            dly_cnt <= dly_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_spi_reader.sv
// Directed/randomized bench for adc_spi_reader against a frame-level ADC and bank model.
// Latency: n/a.
// Backpressure: n/a.
module tb_adc_spi_reader;

  localparam int CLK_DIV    = 4;
  localparam int NUM_CH     = 5;
  localparam int DATA_W     = 10;
  localparam int FB         = 5 + 1 + DATA_W;
  localparam int STROBE_LAT = 1 + CLK_DIV * (1 + 2 * FB);
  localparam int SPACING    = (2 + 2 * FB) * CLK_DIV + 1;

  logic clk_i = 1'b0;
  logic reset_i;

  always #5 clk_i = ~clk_i;

  adc_spi_reader_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) bus ();

  adc_spi_reader #(.CLK_DIV(CLK_DIV), .NUM_CH(NUM_CH), .DATA_W(DATA_W)) dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .bus     (bus.slave)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  // ADC model: queue of conversion results, one popped per chip-select assertion.
  logic [DATA_W-1:0] adc_q[$];
  logic [DATA_W-1:0] cur_val = '0;
  logic              mosi_log[$];
  int                rises = 0;
  logic              prev_sclk = 1'b0;
  logic              prev_cs = 1'b1;

  // Observes SCLK/CS mid-cycle, logs MOSI at each rise, presents the bit for the current period.
  always @(negedge clk_i) begin
    if (prev_cs && !bus.cs_n_o) begin
      rises = 0;
      mosi_log.delete();
      if (adc_q.size() > 0) cur_val = adc_q.pop_front();
      else cur_val = DATA_W'($urandom);
    end
    if (!bus.cs_n_o && bus.sclk_o && !prev_sclk) begin
      rises = rises + 1;
      mosi_log.push_back(bus.mosi_o);
    end
    prev_sclk = bus.sclk_o;
    prev_cs   = bus.cs_n_o;
    if (bus.cs_n_o) bus.miso_i = 1'b0;
    else if (rises < 5) bus.miso_i = 1'($urandom);
    else if (rises == 5) bus.miso_i = 1'b0;
    else if (rises < 6 + DATA_W) bus.miso_i = cur_val[DATA_W - 1 - (rises - 6)];
    else bus.miso_i = 1'b0;
  end

  // Expected result bank.
  logic [DATA_W-1:0] exp_bank [1:NUM_CH];
`ifdef ADC_AVG_EN
  bit exp_wr [1:NUM_CH];
`endif

  task automatic model_reset();
    for (int c = 1; c <= NUM_CH; c++) begin
      exp_bank[c] = '0;
`ifdef ADC_AVG_EN
      exp_wr[c] = 1'b0;
`endif
    end
  endtask

  task automatic model_write(input int ch, input logic [DATA_W-1:0] v);
`ifdef ADC_AVG_EN
    if (exp_wr[ch]) exp_bank[ch] = DATA_W'((int'(exp_bank[ch]) + int'(v) + 1) / 2);
    else exp_bank[ch] = v;
    exp_wr[ch] = 1'b1;
`else
    exp_bank[ch] = v;
`endif
  endtask

  function automatic logic [63:0] exp_vec();
    logic [63:0] v;
    v = '0;
    for (int c = 1; c <= NUM_CH; c++) v[(c-1)*DATA_W +: DATA_W] = exp_bank[c];
    return v;
  endfunction

  function automatic logic [63:0] exp_cmd(input int ch);
    int m;
    m = ch - 1;
    return 64'((1 << 4) | (1 << 3) | (m & 7));
  endfunction

  function automatic logic [63:0] got_cmd();
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < 5 && i < mosi_log.size(); i++) v = (v << 1) | 64'(mosi_log[i]);
    return v;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_strobe(input int budget, output int scyc);
    bit seen;
    seen = 1'b0;
    scyc = -1;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      if (bus.sample_valid_o) begin
        seen = 1'b1;
        scyc = cyc;
      end
    end
    check("strobe_seen", 64'(seen), 64'd1);
  endtask

  task automatic check_result(input string tag, input int ch, input logic [DATA_W-1:0] v);
    check({tag, "_sample"}, 64'(bus.sample_o), 64'(v));
    check({tag, "_ch"}, 64'(bus.sample_ch_o), 64'(ch));
    model_write(ch, v);
    check({tag, "_bank"}, 64'(bus.ch_data_o), exp_vec());
  endtask

  task automatic run_frame(input string tag, input int ch, input logic [DATA_W-1:0] v);
    int c0;
    int s;
    adc_q.push_back(v);
    bus.channel_i = 5'(ch);
    bus.start_i   = 1'b1;
    c0 = cyc;
    tick();
    bus.start_i = 1'b0;
    check({tag, "_cs_fall"}, 64'(bus.cs_n_o), 64'd0);
    check({tag, "_busy_rise"}, 64'(bus.busy_o), 64'd1);
    wait_strobe(STROBE_LAT + 20, s);
    check({tag, "_latency"}, 64'(s - c0), 64'(STROBE_LAT));
    check_result(tag, ch, v);
    check({tag, "_mosi_cmd"}, got_cmd(), exp_cmd(ch));
    check({tag, "_sclk_rises"}, 64'(rises), 64'(FB));
    repeat (CLK_DIV - 1) tick();
    check({tag, "_busy_hold"}, 64'(bus.busy_o), 64'd1);
    tick();
    check({tag, "_busy_fall"}, 64'(bus.busy_o), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    int sv [3];
    int r;
    int ch;
    int ch2;
    int cnt;
    bit flag;
    logic ps;
    logic [DATA_W-1:0] v;
    logic [DATA_W-1:0] vals [3];
    int bad [3];

    bus.channel_i = 5'd0;
    bus.start_i   = 1'b0;
    reset_i       = 1'b1;
    model_reset();
    #1;
    // Reset values.
    check("rst_cs_n", 64'(bus.cs_n_o), 64'd1);
    check("rst_sclk", 64'(bus.sclk_o), 64'd0);
    check("rst_mosi", 64'(bus.mosi_o), 64'd0);
    check("rst_busy", 64'(bus.busy_o), 64'd0);
    check("rst_valid", 64'(bus.sample_valid_o), 64'd0);
    check("rst_sample_ch", 64'(bus.sample_ch_o), 64'd0);
    check("rst_sample", 64'(bus.sample_o), 64'd0);
    check("rst_bank", 64'(bus.ch_data_o), 64'd0);
    repeat (3) tick();
    reset_i = 1'b0;
    repeat (2) tick();

    // Asynchronous reset at the 8th SCLK rise.
    ch = $urandom_range(1, NUM_CH);
    adc_q.push_back(DATA_W'($urandom_range(1, 1023)));
    bus.channel_i = 5'(ch);
    bus.start_i   = 1'b1;
    tick();
    bus.start_i = 1'b0;
    r = 0;
    ps = 1'b0;
    flag = 1'b0;
    for (int i = 0; i < 200 && r < 8; i++) begin
      tick();
      if (bus.sample_valid_o) flag = 1'b1;
      if (bus.sclk_o && !ps) r++;
      ps = bus.sclk_o;
    end
    check("arst_rise8_reached", 64'(r), 64'd8);
    reset_i = 1'b1;
    #1;
    check("arst_cs_n", 64'(bus.cs_n_o), 64'd1);
    check("arst_sclk", 64'(bus.sclk_o), 64'd0);
    check("arst_busy", 64'(bus.busy_o), 64'd0);
    repeat (2) tick();
    reset_i = 1'b0;
    for (int i = 0; i < STROBE_LAT + 20; i++) begin
      tick();
      if (bus.sample_valid_o || !bus.cs_n_o) flag = 1'b1;
    end
    check("arst_no_strobe", 64'(flag), 64'd0);
    check("arst_bank_zero", 64'(bus.ch_data_o), exp_vec());

    // Single frame, channel 3.
    run_frame("single", 3, 10'h2A5);
    check("single_slot3", 64'(bus.ch_data_o[29:20]), 64'h2A5);

    // Channel sweep with distinct random values.
    for (int c = 1; c <= NUM_CH; c++) begin
      v = DATA_W'((c - 1) * 200 + $urandom_range(1, 199));
      run_frame("sweep", c, v);
    end

    // Out-of-range channels must not start a frame.
    bad[0] = 0;
    bad[1] = NUM_CH + 1;
    bad[2] = $urandom_range(NUM_CH + 2, 31);
    for (int b = 0; b < 3; b++) begin
      flag = 1'b0;
      bus.channel_i = 5'(bad[b]);
      bus.start_i   = 1'b1;
      for (int i = 0; i < 20; i++) begin
        tick();
        if (!bus.cs_n_o || bus.sample_valid_o || bus.busy_o) flag = 1'b1;
      end
      bus.start_i = 1'b0;
      check("reject_no_frame", 64'(flag), 64'd0);
    end
    check("reject_bank", 64'(bus.ch_data_o), exp_vec());

    // Start and channel change mid-frame are ignored.
    ch  = $urandom_range(1, NUM_CH);
    ch2 = (ch % NUM_CH) + 1;
    v   = DATA_W'($urandom_range(0, 1023));
    adc_q.push_back(v);
    bus.channel_i = 5'(ch);
    bus.start_i   = 1'b1;
    tick();
    bus.start_i = 1'b0;
    repeat (40) tick();
    bus.channel_i = 5'(ch2);
    bus.start_i   = 1'b1;
    repeat (30) tick();
    bus.start_i = 1'b0;
    wait_strobe(STROBE_LAT, s);
    check_result("midstart", ch, v);
    cnt = 0;
    for (int i = 0; i < STROBE_LAT + 20; i++) begin
      tick();
      if (bus.sample_valid_o) cnt++;
    end
    check("midstart_extra_strobes", 64'(cnt), 64'd0);

    // Back-to-back frames with start held high.
    ch = $urandom_range(1, NUM_CH);
    for (int i = 0; i < 3; i++) begin
      vals[i] = DATA_W'($urandom_range(0, 1023));
      adc_q.push_back(vals[i]);
    end
    bus.channel_i = 5'(ch);
    bus.start_i   = 1'b1;
    r = cyc;
    for (int i = 0; i < 3; i++) begin
      wait_strobe(SPACING + 20, sv[i]);
      if (i == 2) bus.start_i = 1'b0;
      check_result("b2b", ch, vals[i]);
    end
    check("b2b_first_latency", 64'(sv[0] - r), 64'(STROBE_LAT));
    check("b2b_spacing_1", 64'(sv[1] - sv[0]), 64'(SPACING));
    check("b2b_spacing_2", 64'(sv[2] - sv[1]), 64'(SPACING));
    repeat (CLK_DIV + 2) tick();
    check("b2b_idle", 64'(bus.busy_o), 64'd0);

    // Two writes to channel 2 after a fresh reset (averaged when the filter is built in).
    reset_i = 1'b1;
    model_reset();
    tick();
    reset_i = 1'b0;
    tick();
    check("avg_rst_bank", 64'(bus.ch_data_o), 64'd0);
    run_frame("avg1", 2, 10'h100);
    run_frame("avg2", 2, 10'h201);
`ifdef ADC_AVG_EN
    check("avg_slot2", 64'(bus.ch_data_o[19:10]), 64'h181);
`else
    check("raw_slot2", 64'(bus.ch_data_o[19:10]), 64'h201);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
